// File: rtl/sysid_checker.sv
// sysid_checker: boot-time Avalon-MM master that reads the system-ID word
// (address 0) and build timestamp (address 1) from the sysid slave and flags
// whether they match the values this software build was compiled against.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_1234,
  parameter logic [31:0] EXPECTED_TS    = 32'h613B_AE19,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ID   = 3'd1;
  localparam logic [2:0] S_WAIT_ID = 3'd2;
  localparam logic [2:0] S_RD_TS   = 3'd3;
  localparam logic [2:0] S_WAIT_TS = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [2:0]  state_q, state_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] read_id_q, read_id_d;
  logic [31:0] read_ts_q, read_ts_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        auto_q, auto_d;
  logic [15:0] cnt_inc;

  // Next-state and output decode. The ID read is raised one cycle after
  // entering RD_ID (the entry cycle clears results); the TS read is raised
  // on the same edge that captures the ID word. A read is only accepted
  // when it was actually presented (avm_read_q) and not stalled.
  always_comb begin
    state_d       = state_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = done_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_d     = timeout_q;
    read_id_d     = read_id_q;
    read_ts_d     = read_ts_q;
    tmo_cnt_d     = tmo_cnt_q;
    auto_d        = 1'b0;
    cnt_inc       = tmo_cnt_q + 16'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start || auto_q) begin
          state_d       = S_RD_ID;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_d     = 1'b0;
          read_id_d     = '0;
          read_ts_d     = '0;
          avm_read_d    = 1'b0;
          avm_address_d = 1'b0;
          tmo_cnt_d     = '0;
        end
      end
      S_RD_ID, S_RD_TS: begin
        tmo_cnt_d = cnt_inc;
        if (cnt_inc == TMO_LIMIT) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
          avm_read_d = 1'b0;
        end else if (avm_read_q && !avm_waitrequest) begin
          avm_read_d = 1'b0;
          state_d    = (state_q == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
        end else begin
          avm_read_d = 1'b1;
        end
      end
      S_WAIT_ID: begin
        tmo_cnt_d = cnt_inc;
        if (avm_readdatavalid) begin
          read_id_d     = avm_readdata;
          id_ok_d       = (avm_readdata == EXPECTED_ID);
          state_d       = S_RD_TS;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b1;
          tmo_cnt_d     = '0;
        end else if (cnt_inc == TMO_LIMIT) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_WAIT_TS: begin
        tmo_cnt_d = cnt_inc;
        if (avm_readdatavalid) begin
          read_ts_d = avm_readdata;
          ts_ok_d   = CHECK_TS ? (avm_readdata == EXPECTED_TS) : 1'b1;
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else if (cnt_inc == TMO_LIMIT) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any check and arms auto-start.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      read_id_q     <= '0;
      read_ts_q     <= '0;
      tmo_cnt_q     <= '0;
      auto_q        <= AUTO_START;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      read_id_q     <= read_id_d;
      read_ts_q     <= read_ts_d;
      tmo_cnt_q     <= tmo_cnt_d;
      auto_q        <= auto_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign read_id     = read_id_q;
  assign read_ts     = read_ts_q;

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Boot-time Avalon-MM master that reads the two system-ID words (ID at word 0, build timestamp at word 1) from the sysid slave and compares them against values the software build expects. It sits directly upstream of the sysid slave on the Qsys interconnect. It gives the Ethernet bring-up logic a hardware "correct bitstream" flag before the NIOS/MAC path is released from reset.

## Interface
- EXPECTED_ID, 32'h0000_1234, value word 0 must return
- EXPECTED_TS, 32'h613B_AE19, value word 1 must return
- CHECK_TS, 1, 1 = timestamp mismatch clears ts_ok; 0 = ts_ok forced to 1 once word 1 is read
- TIMEOUT_CYCLES, 255, maximum cycles per read transaction (1..65535)
- AUTO_START, 1, 1 = one check launched automatically after reset release
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle request to run a check
- avm_address  out  1  word select: 0 = ID, 1 = timestamp
- avm_read  out  1  read request, held until accepted
- avm_waitrequest  in  1  slave/interconnect stall
- avm_readdatavalid  in  1  read data qualifier
- avm_readdata  in  32  read data
- busy  out  1  check in progress
- done  out  1  check finished; held until the next start
- id_ok  out  1  word 0 == EXPECTED_ID
- ts_ok  out  1  word 1 == EXPECTED_TS (see CHECK_TS)
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES
- read_id  out  32  captured word 0
- read_ts  out  32  captured word 1

## Operation
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- IDLE/DONE + start=1 -> RD_ID. On entry: clear done, id_ok, ts_ok, timeout, read_id, read_ts; set busy.
- First cycle out of reset with AUTO_START=1 behaves as start=1.
- RD_ID: avm_read=1, avm_address=0. If avm_waitrequest=0 -> WAIT_ID.
- WAIT_ID: avm_read=0. If avm_readdatavalid=1: capture read_id, evaluate id_ok, -> RD_TS.
- RD_TS/WAIT_TS: same rules with avm_address=1, capturing read_ts and evaluating ts_ok. On valid -> DONE.
- DONE: busy=0, done=1. Results stay stable until the next start.
- avm_readdatavalid is ignored outside WAIT_ID/WAIT_TS. Interconnect read latency is ≥1 cycle.
- start while busy=1 is ignored. start in DONE re-runs the check.
- Timeout: 16-bit counter cleared on entry to RD_ID and RD_TS. It increments every cycle in RD_x/WAIT_x. On reaching TIMEOUT_CYCLES -> DONE with timeout=1, avm_read=0, and id_ok/ts_ok left at 0 for any unread word.
- Only one outstanding read at a time. avm_read is never asserted while a read is pending.
- Comparisons are full 32-bit equality. No masking.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, read_id=0, read_ts=0. State = IDLE.
- Reset asserted mid-check: the abort takes effect on that edge, and no results are kept. With AUTO_START=1, the check restarts after release.
- All outputs are registered.
- Minimum latency with zero wait states and 1-cycle read latency:
  - start sampled at edge 0;
  - avm_read high in cycle 1, accepted at edge 2;
  - ID valid in cycle 2;
  - TS read in cycle 3, valid in cycle 4;
  - done=1 from edge 5.
- avm_address and avm_read hold constant while avm_waitrequest=1.
- Timeout fires exactly TIMEOUT_CYCLES cycles after entry to the stalled RD_x state.

## Test plan
- Nominal: slave returns 0x00001234, then 0x613BAE19, 1-cycle latency, no stalls -> done at edge 5, id_ok=1, ts_ok=1, timeout=0.
- Wrong timestamp 0x613BAE18, CHECK_TS=1 -> id_ok=1, ts_ok=0, read_ts=0x613BAE18. Same with CHECK_TS=0 -> ts_ok=1.
- avm_waitrequest held high 10 cycles on the ID read -> avm_read/avm_address stable throughout, correct results, done 10 cycles later than nominal.
- TIMEOUT_CYCLES=8, readdatavalid never asserted on the TS read -> timeout=1, id_ok=1, ts_ok=0, avm_read=0, done=1.
- start pulsed while busy, and spurious readdatavalid in RD_ID -> both ignored, results unchanged from the nominal run.
- reset_n low for 1 cycle during WAIT_TS -> all outputs zero the next cycle. With AUTO_START=1 a fresh check completes with id_ok=ts_ok=1.
